// File: rtl/ifu_if.sv
// Fetch-unit port bundle: instruction-memory request/response, redirect and decode handshake.
// The master modport is the fetch unit; slave is its environment (memory, branch unit, decoder).
interface ifu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  o_imem_req_valid;
  logic                  i_imem_req_ready;
  logic [ADDR_WIDTH-1:0] o_imem_req_addr;
  logic                  i_imem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_imem_rsp_data;
  logic                  i_jmp_en;
  logic [ADDR_WIDTH-1:0] i_jmp_pc;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_inst;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_misalign;

  modport master (
    output o_imem_req_valid, o_imem_req_addr, o_valid, o_inst, o_pc, o_misalign,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_jmp_en, i_jmp_pc, i_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_req_addr, o_valid, o_inst, o_pc, o_misalign,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_jmp_en, i_jmp_pc, i_ready
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues credit-limited fetches, buffers (inst,pc) for decode.
// Optional macro IFU_MISALIGN_CHK_EN: misaligned redirects raise sticky o_misalign and halt issue.
module ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic   i_clk,
  input  logic   i_rst,
  ifu_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [PW-1:0]         ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FIFO_DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  addr_t pc_q, pc_d;
  cnt_t  count_q, count_d;
  cnt_t  pend_q, pend_d;
  cnt_t  drop_q, drop_d;
  ptr_t  wr_q, wr_d, rd_q, rd_d;
  ptr_t  trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;

  data_t buf_inst [FIFO_DEPTH];
  addr_t buf_pc   [FIFO_DEPTH];
  addr_t trk_pc   [FIFO_DEPTH];

  logic          jmp, rsp, halt, credit_ok, req_valid, acc, rsp_drop, push, pop;
  logic [CW:0]   occupancy;
  addr_t         jmp_tgt;

  assign jmp = bus.i_jmp_en;
  assign rsp = bus.i_imem_rsp_valid;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign jmp_tgt    = bus.i_jmp_pc;
  assign halt       = misalign_q;
  assign misalign_d = jmp ? (|bus.i_jmp_pc[1:0]) : misalign_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign bus.o_misalign = misalign_q;
`else
  logic unused_jmp_lsb;

  assign unused_jmp_lsb = ^bus.i_jmp_pc[1:0];
  assign jmp_tgt        = {bus.i_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
  assign halt           = 1'b0;
  assign bus.o_misalign = 1'b0;
`endif

  // Credit covers both buffered and in-flight words, so a response can never find the buffer full.
  assign occupancy = {1'b0, count_q} + {1'b0, pend_q};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
  assign req_valid = !i_rst && !jmp && credit_ok && !halt;
  assign acc       = req_valid && bus.i_imem_req_ready;

  assign rsp_drop  = rsp && (drop_q != '0);
  assign push      = rsp && !rsp_drop && !jmp;
  assign pop       = (count_q != '0) && bus.i_ready && !jmp;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    pend_d   = pend_q + cnt_t'(acc) - cnt_t'(rsp);
    drop_d   = drop_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    trk_wr_d = acc ? ptr_inc(trk_wr_q) : trk_wr_q;
    trk_rd_d = rsp ? ptr_inc(trk_rd_q) : trk_rd_q;

    if (jmp) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      pc_d    = jmp_tgt;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      drop_d  = pend_q - cnt_t'(rsp);
    end else begin
      if (acc)      pc_d   = pc_q + addr_t'(4);
      if (rsp_drop) drop_d = drop_q - cnt_t'(1);
      if (push)     wr_d   = ptr_inc(wr_q);
      if (pop)      rd_d   = ptr_inc(rd_q);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      trk_wr_q <= '0;
      trk_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      trk_wr_q <= trk_wr_d;
      trk_rd_q <= trk_rd_d;
    end
  end

  // Storage carries no reset; occupancy counters alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (acc) trk_pc[trk_wr_q] <= pc_q;
    if (push) begin
      buf_inst[wr_q] <= bus.i_imem_rsp_data;
      buf_pc[wr_q]   <= trk_pc[trk_rd_q];
    end
  end

  assign bus.o_imem_req_valid = req_valid;
  assign bus.o_imem_req_addr  = pc_q;
  assign bus.o_valid          = (count_q != '0);
  assign bus.o_inst           = buf_inst[rd_q];
  assign bus.o_pc             = buf_pc[rd_q];

endmodule
